// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encodings, timing constants and pixel type for the ws2812 chain.
package ws2812_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_SCALE, S_OFFER, S_GAP} state_t;
    localparam int DELAY_RESET = 13500;
    // serializer bit timings in 27 MHz clk cycles
    localparam int T0H = 10;
    localparam int T0L = 22;
    localparam int T1H = 19;
    localparam int T1L = 16;
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;
    function automatic pixel_t grb_pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return pixel_t'({g, r, b});
    endfunction
endpackage

// File: rtl/ws2812_pixel_ram.sv
// ws2812_pixel_ram: simple dual-port synchronous RAM, 1-cycle read, read-before-write.
module ws2812_pixel_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    always_ff @(posedge clk) begin
        if (we && 32'(waddr) < DEPTH) mem[waddr[IW-1:0]] <= wdata;
        if (re) rd_q <= mem[raddr[IW-1:0]];
    end
    assign rdata = rd_q;
endmodule

// File: rtl/ws2812_frame_feeder.sv
// ws2812_frame_feeder: streams a RAM-held frame of GRB pixels to the serializer, then holds the latch gap.
// Optional WS2812_BRIGHTNESS_EN adds a brightness port and a per-channel scaling stage.
module ws2812_frame_feeder
    import ws2812_pkg::*;
#(
    parameter int NUM_LEDS    = 8,
    parameter int ADDR_W      = 3,
    parameter int DELAY_RESET = ws2812_pkg::DELAY_RESET
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_r,
    input  logic [7:0]        wr_g,
    input  logic [7:0]        wr_b,
    input  logic              show,
    output logic              busy,
    output logic              pix_valid,
    output logic [23:0]       pix_data,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic              frame_done
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]        brightness
`endif
);
    localparam int CW = $clog2(DELAY_RESET + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);
    state_t state_q, state_d;
    logic busy_q, busy_d, valid_q, valid_d, done_q, done_d;
    logic [23:0] data_q, data_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [23:0] ram_rd;

    ws2812_pixel_ram #(.DEPTH(NUM_LEDS), .WIDTH(24), .AW(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (grb_pack(wr_r, wr_g, wr_b)),
        .re    (state_q == S_FETCH),
        .raddr (idx_q),
        .rdata (ram_rd)
    );

`ifdef WS2812_BRIGHTNESS_EN
    // (c * (k + 1)) >> 8 keeps 0xFF as identity and 0x00 as black
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] k);
        logic [15:0] p;
        p = 16'(c) * (16'(k) + 16'd1);
        return p[15:8];
    endfunction
    pixel_t px;
    assign px = pixel_t'(data_q);
`endif

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: if (show) begin
                busy_d  = 1'b1;
                idx_d   = '0;
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                data_d = ram_rd;
`ifdef WS2812_BRIGHTNESS_EN
                state_d = S_SCALE;
`else
                valid_d = 1'b1;
                state_d = S_OFFER;
`endif
            end
`ifdef WS2812_BRIGHTNESS_EN
            S_SCALE: begin
                data_d  = {scale(px.g, brightness), scale(px.r, brightness), scale(px.b, brightness)};
                valid_d = 1'b1;
                state_d = S_OFFER;
            end
`endif
            S_OFFER: if (pix_ready) begin
                valid_d = 1'b0;
                cnt_d   = '0;
                idx_d   = idx_q == LAST ? idx_q : idx_q + 1'b1;
                state_d = idx_q == LAST ? S_GAP : S_FETCH;
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DELAY_RESET - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign pix_valid  = valid_q;
    assign pix_data   = data_q;
    assign pix_last   = valid_q && idx_q == LAST;
    assign frame_done = done_q;
endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// tb_ws2812_frame_feeder: directed self-checking bench, 4 LEDs and a short latch gap.
module tb_ws2812_frame_feeder;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int D  = 20;
`ifdef WS2812_BRIGHTNESS_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    logic clk = 0, rst = 1, wr_en = 0, show = 0, pix_ready = 0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0] wr_r = 0, wr_g = 0, wr_b = 0;
    logic busy, pix_valid, pix_last, frame_done;
    logic [23:0] pix_data;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] brightness = 8'hFF;
`endif
    logic [23:0] exp_px [N];
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    ws2812_frame_feeder #(.NUM_LEDS(N), .ADDR_W(AW), .DELAY_RESET(D)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .show(show),
        .busy(busy), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .pix_last(pix_last), .frame_done(frame_done)
`ifdef WS2812_BRIGHTNESS_EN
        , .brightness(brightness)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_en = 1; wr_addr = a; wr_r = r; wr_g = g; wr_b = b;
        tick();
        wr_en = 0;
    endtask

    task automatic start_frame;
        show = 1;
        tick();
        show = 0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (pix_valid) begin ok = 1; break; end
            tick();
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!frame_done && n < D + 10) begin tick(); n++; end
    endtask

    task automatic test_reset;
        rst = 1;
        tick(); tick();
        vectors++;
        if ({busy, pix_valid, pix_last, frame_done} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {busy, pix_valid, pix_last, frame_done});
        end
        vectors++;
        if (pix_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", pix_data); end
        rst = 0;
        tick();
    endtask

    task automatic test_frame;
        bit ok;
        int n;
        write_px(0, 8'h01, 8'h02, 8'h03);
        write_px(1, 8'h11, 8'h12, 8'h13);
        write_px(2, 8'h21, 8'h22, 8'h23);
        write_px(3, 8'h31, 8'h32, 8'h33);
        pix_ready = 1;
        start_frame();
        for (int i = 1; i < LAT; i++) tick();
        vectors++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL frame_early_valid got %b exp 0", pix_valid); end
        tick();
        vectors++;
        if (pix_valid !== 1'b1) begin errors++; $display("FAIL frame_latency got %b exp 1", pix_valid); end
        for (int i = 0; i < N; i++) begin
            wait_valid(ok);
            vectors++;
            if (!ok) begin errors++; $display("FAIL frame_timeout px %0d got no valid exp valid", i); end
            vectors++;
            if (pix_data !== exp_px[i] || pix_last !== (i == N - 1)) begin
                errors++; $display("FAIL frame_px%0d got %h last %b exp %h last %b", i, pix_data, pix_last, exp_px[i], i == N - 1);
            end
            tick();
        end
        wait_done(n);
        vectors++;
        if (n !== D) begin errors++; $display("FAIL frame_gap got %0d exp %0d", n, D); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_drop got %b exp 0", busy); end
        tick();
        vectors++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got %b exp 0", frame_done); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        pix_ready = 1;
        start_frame();
        wait_valid(ok);
        tick();
        wait_valid(ok);
        pix_ready = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (pix_valid !== 1'b1 || pix_data !== exp_px[1] || pix_last !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc %0d got v%b %h exp v1 %h", i, pix_valid, pix_data, exp_px[1]);
            end
        end
        pix_ready = 1;
        tick();
        for (int i = 2; i < N; i++) begin
            wait_valid(ok);
            vectors++;
            if (!ok || pix_data !== exp_px[i]) begin errors++; $display("FAIL bp_px%0d got %h exp %h", i, pix_data, exp_px[i]); end
            tick();
        end
        wait_done(n);
        vectors++;
        if (n !== D) begin errors++; $display("FAIL bp_gap got %0d exp %0d", n, D); end
    endtask

    task automatic test_show_ignored;
        bit ok;
        int n;
        pix_ready = 1;
        start_frame();
        wait_valid(ok);
        tick();
        write_px(7, 8'hEE, 8'hEE, 8'hEE);
        start_frame();
        for (int i = 1; i < N; i++) begin
            wait_valid(ok);
            vectors++;
            if (!ok || pix_data !== exp_px[i]) begin errors++; $display("FAIL ign_px%0d got %h exp %h", i, pix_data, exp_px[i]); end
            tick();
        end
        wait_done(n);
        vectors++;
        if (n !== D) begin errors++; $display("FAIL ign_gap got %0d exp %0d", n, D); end
        tick();
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ign_requeued got busy %b exp 0", busy); end
        start_frame();
        for (int i = 0; i < N; i++) begin
            wait_valid(ok);
            vectors++;
            if (!ok || pix_data !== exp_px[i]) begin errors++; $display("FAIL badaddr_px%0d got %h exp %h", i, pix_data, exp_px[i]); end
            tick();
        end
        wait_done(n);
        tick();
    endtask

    task automatic test_done_show;
        bit ok;
        int n;
        pix_ready = 1;
        start_frame();
        for (int i = 0; i < N; i++) begin wait_valid(ok); tick(); end
        for (int k = 0; k < D - 1; k++) tick();
        show = 1;
        tick();
        vectors++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL done_show_edge got done %b busy %b exp done 1 busy 0", frame_done, busy);
        end
        tick();
        show = 0;
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL done_show_next got busy %b exp 1", busy); end
        for (int i = 0; i < N; i++) begin wait_valid(ok); tick(); end
        wait_done(n);
        vectors++;
        if (n !== D) begin errors++; $display("FAIL done_show_gap got %0d exp %0d", n, D); end
        tick();
    endtask

    task automatic test_reset_mid;
        bit ok;
        pix_ready = 1;
        start_frame();
        for (int i = 0; i < 2; i++) begin wait_valid(ok); tick(); end
        wait_valid(ok);
        vectors++;
        if (!ok || pix_data !== exp_px[2]) begin errors++; $display("FAIL rstmid_px2 got %h exp %h", pix_data, exp_px[2]); end
        rst = 1;
        tick();
        rst = 0;
        vectors++;
        if ({busy, pix_valid} !== 2'b00 || pix_data !== 24'h0) begin
            errors++; $display("FAIL rstmid_clear got busy %b v %b %h exp 0 0 000000", busy, pix_valid, pix_data);
        end
        start_frame();
        for (int i = 1; i < LAT; i++) tick();
        vectors++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early got %b exp 0", pix_valid); end
        tick();
        vectors++;
        if (pix_valid !== 1'b1 || pix_data !== exp_px[0]) begin
            errors++; $display("FAIL rstmid_restart got v %b %h exp v 1 %h", pix_valid, pix_data, exp_px[0]);
        end
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_same_cycle_write;
        bit ok;
        int n;
        pix_ready = 1;
        start_frame();
        for (int i = 0; i < 2; i++) begin wait_valid(ok); tick(); end
        write_px(2, 8'hA1, 8'hA2, 8'hA3);
        wait_valid(ok);
        vectors++;
        if (!ok || pix_data !== exp_px[2]) begin errors++; $display("FAIL rw_old got %h exp %h", pix_data, exp_px[2]); end
        tick();
        wait_valid(ok);
        tick();
        wait_done(n);
        tick();
        start_frame();
        for (int i = 0; i < 2; i++) begin wait_valid(ok); tick(); end
        wait_valid(ok);
        vectors++;
        if (!ok || pix_data !== 24'hA2A1A3) begin errors++; $display("FAIL rw_new got %h exp a2a1a3", pix_data); end
        rst = 1;
        tick();
        rst = 0;
    endtask

`ifdef WS2812_BRIGHTNESS_EN
    task automatic test_brightness;
        logic [7:0]  br [3];
        logic [23:0] ex [3];
        br[0] = 8'h7F; ex[0] = 24'h407F00;
        br[1] = 8'hFF; ex[1] = 24'h80FF01;
        br[2] = 8'h00; ex[2] = 24'h000000;
        write_px(0, 8'hFF, 8'h80, 8'h01);
        pix_ready = 0;
        for (int j = 0; j < 3; j++) begin
            brightness = br[j];
            start_frame();
            tick(); tick();
            vectors++;
            if (pix_valid !== 1'b0) begin errors++; $display("FAIL br_early %0d got %b exp 0", j, pix_valid); end
            tick();
            vectors++;
            if (pix_valid !== 1'b1 || pix_data !== ex[j]) begin
                errors++; $display("FAIL br_%h got v %b %h exp v 1 %h", br[j], pix_valid, pix_data, ex[j]);
            end
            rst = 1;
            tick();
            rst = 0;
        end
        brightness = 8'hFF;
    endtask
`endif

    initial begin
        exp_px[0] = 24'h020103;
        exp_px[1] = 24'h121113;
        exp_px[2] = 24'h222123;
        exp_px[3] = 24'h323133;
        test_reset();
        test_frame();
        test_backpressure();
        test_show_ignored();
        test_done_show();
        test_reset_mid();
        test_same_cycle_write();
`ifdef WS2812_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
